sha3_digest_reader: RTL and testbench
=====================================

Name: sha3_digest_reader

Overview:
- Downstream consumer of the SHA3 core's squeeze interface.
- While the core exposes its state (squeezing, state valid), it serializes the rate portion of the Keccak state into a 64-bit valid/ready word stream for hardware consumers (app/keymgr path).
- Supports XOF output longer than one rate block: it pulses `run_o` to request another Keccak-f, waits for completion, then resumes streaming.
- It ends the squeeze with a `done_o` pulse.

Parameters:
- `EnMasking`, default 0: state input has 2 shares if 1, else 1. Shares are XOR-combined internally.
- `MaxOutBytes`, default 512: maximum requested output length in bytes. Sets `LenW = $clog2(MaxOutBytes+1)`.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `start_i` in 1: pulse; begin a digest readout.
- `out_len_i` in LenW: requested output bytes, sampled on `start_i`.
- `strength_i` in 3: keccak_strength_e, sampled on `start_i`; selects rate.
- `state_valid_i` in 1: SHA3 state valid (squeezing).
- `state_i` in StateW x Share: Keccak state shares (StateW=1600).
- `block_processed_i` in 1: pulse; Keccak-f round complete.
- `run_o` out 1: pulse; request manual Keccak run.
- `done_o` out 1: pulse; squeeze complete, core may flush.
- `out_valid_o` out 1: output word valid.
- `out_data_o` out 64: output word, little-endian byte order from state bit 0.
- `out_strb_o` out 8: valid bytes of the word; all ones except possibly the last word.
- `out_last_o` out 1: final word of the digest.
- `out_ready_i` in 1: consumer accepts the word.
- `busy_o` out 1: not in StIdle.
- `error_o` out 1: pulse; illegal control event.
- `sparse_fsm_error_o` out 1: FSM in an invalid encoding.

Behaviour:
- **Reset values:** all outputs 0; FSM StIdle; counters 0.
- **Rate in 64-bit words (RateWords):** L128=21, L224=18, L256=17, L384=13, L512=9. Any other strength value is an error.
- **FSM** (sparse-encoded, held in prim_sparse_fsm_flop): StIdle, StWaitValid, StStream, StWaitRun, StDone, StTerminal.
- **StIdle:**
  - `start_i` with `out_len_i` in 1..MaxOutBytes and a legal strength: latch `rem = out_len_i` and RateWords, set `widx = 0`, go to StWaitValid.
  - `out_len_i == 0`, `out_len_i > MaxOutBytes`, or an illegal strength: `error_o` pulse, stay in StIdle.
- **StWaitValid:** when `state_valid_i == 1`, go to StStream. No output in this state.
- **StStream:**
  - `out_valid_o = state_valid_i`.
  - `out_data_o` = (XOR of shares)[64*widx +: 64], a combinational mux on registered `widx`.
  - If `rem <= 8`: `out_strb_o = (1 << rem) - 1`, `out_last_o = 1`. Otherwise `out_strb_o = 0xFF`.
  - On handshake (`out_valid_o && out_ready_i`):
    - last word: go to StDone.
    - else if `widx == RateWords-1`: `rem -= 8`, `widx = 0`, assert `run_o` for exactly one cycle (registered, the cycle after the handshake), go to StWaitRun.
    - else: `rem -= 8`, `widx += 1`.
  - `state_valid_i` drops in StStream: `error_o` pulse, go to StIdle, no `done_o`.
  - Holding `out_ready_i` low keeps data and strobe stable for as long as `state_valid_i` stays high.
- **StWaitRun:** on `block_processed_i`, go to StWaitValid. `block_processed_i` is also accepted in the same cycle `run_o` is high.
- **StDone:** assert `done_o` for one cycle, then go to StIdle. Latency from the last handshake to `done_o` is 1 cycle.
- **StTerminal / invalid encoding:**
  - Any invalid encoding goes to StTerminal.
  - StTerminal is terminal: `sparse_fsm_error_o = 1` constantly, all stream outputs 0, leaves only by reset.
- **Illegal and boundary events:**
  - `start_i` while busy: `error_o` pulse, ignored.
  - `block_processed_i` outside StWaitRun: ignored.
- **Width rules:** `rem` is LenW bits and never underflows, because a decrement happens only when `rem > 8`. `widx` is 5 bits.
- **Reset mid-operation:** immediate return to StIdle; `run_o` and `done_o` are never emitted on reset.

Decomposition:
- Add to `sha3_pkg`:
  - the `reader_st_sparse_e` encoding and `ReaderStateWidth`;
  - a `rate_words(keccak_strength_e)` function returning RateWords, reusing the existing keccak_strength_e.
- No new sub-module; instantiate `prim_sparse_fsm_flop` for the state register.

Test Plan:
- **Short digest:** L256, `out_len_i = 32`, `state_valid_i` held, `out_ready_i = 1` → 4 words, strb 0xFF each, last on word 3, `done_o` 1 cycle later, `run_o` never.
- **Partial last word:** L512, `out_len_i = 20` → 3 words, strb 0xFF, 0xFF, 0x0F; `out_data_o` word 2 low bytes = state[191:128] bytes 0..3.
- **XOF across blocks:** L128, `out_len_i = 200` → 21 words, then `run_o` pulse. After `block_processed_i` and `state_valid_i`, 4 more words (strb 0xFF, 0xFF, 0xFF, 0xFF with last; 200 - 168 = 32 bytes), then `done_o`.
- **Backpressure:** `out_ready_i` toggled randomly, masked EnMasking=1 with random shares → data and strobe stable while stalled; the stream equals the XOR of the shares.
- **Errors:**
  - `out_len_i = 0` → `error_o`, no busy.
  - `start_i` mid-stream → `error_o`, stream unaffected.
  - `state_valid_i` dropped mid-stream → `error_o`, StIdle, no `done_o`.
- **Reset / FSM fault:** `rst_ni` asserted in StWaitRun → all outputs 0, StIdle. A forced invalid state encoding → `sparse_fsm_error_o` stays high until reset.

Source files
------------

// File: rtl/sha3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha3_pkg
// Description : Shared SHA3 types. Holds the Keccak strength encoding, the
//               digest reader sparse state encoding and the rate lookup.
// Revision    : 1.0 - initial digest reader additions
// ============================================================================
package sha3_pkg;

    localparam int StateW   = 1600;
    localparam int NumLanes = StateW / 64;

    typedef enum logic [2:0] {
        L128 = 3'h0,
        L224 = 3'h1,
        L256 = 3'h2,
        L384 = 3'h3,
        L512 = 3'h4
    } keccak_strength_e;

    // Every pair of codes differs in at least three bits so that a single
    // upset can never land on another legal state.
    localparam int ReaderStateWidth = 6;

    typedef enum logic [ReaderStateWidth-1:0] {
        StIdle      = 6'b101100,
        StWaitValid = 6'b010110,
        StStream    = 6'b110001,
        StWaitRun   = 6'b001011,
        StDone      = 6'b111111,
        StTerminal  = 6'b000000
    } reader_st_sparse_e;

    // Rate of the sponge in 64-bit lanes; zero marks an unsupported strength.
    function automatic logic [4:0] rate_words(keccak_strength_e s);
        logic [4:0] words;
        words = 5'd0;
        case (s)
            L128:    words = 5'd21;
            L224:    words = 5'd18;
            L256:    words = 5'd17;
            L384:    words = 5'd13;
            L512:    words = 5'd9;
            default: words = 5'd0;
        endcase
        return words;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prim_sparse_fsm_flop.sv
`default_nettype none
// ============================================================================
// Module      : prim_sparse_fsm_flop
// Description : State register for sparse-encoded FSMs, kept as a distinct
//               instance so the state flops are easy to locate.
// Revision    : 1.0 - initial version
// ============================================================================
module prim_sparse_fsm_flop #(
    parameter int               Width      = 1,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] state_i,
    output logic [Width-1:0] state_o
);

    logic [Width-1:0] state_q;

    // Plain state flop with asynchronous reset to the idle code.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ResetValue;
        end else begin
            state_q <= state_i;
        end
    end

    assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/sha3_digest_reader.sv
`default_nettype none
// ============================================================================
// Module      : sha3_digest_reader
// Description : Serializes the rate part of the squeezed Keccak state into a
//               64-bit valid/ready stream, requesting extra Keccak-f runs for
//               XOF outputs longer than one rate block.
// Revision    : 1.0 - initial version
// ============================================================================
module sha3_digest_reader
    import sha3_pkg::*;
#(
    parameter  int EnMasking   = 0,
    parameter  int MaxOutBytes = 512,
    localparam int NumShare    = (EnMasking != 0) ? 2 : 1,
    localparam int LenW        = $clog2(MaxOutBytes + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             start_i,
    input  logic [LenW-1:0]                  out_len_i,
    input  logic [2:0]                       strength_i,
    input  logic                             state_valid_i,
    input  logic [NumShare-1:0][StateW-1:0]  state_i,
    input  logic                             block_processed_i,
    output logic                             run_o,
    output logic                             done_o,
    output logic                             out_valid_o,
    output logic [63:0]                      out_data_o,
    output logic [7:0]                       out_strb_o,
    output logic                             out_last_o,
    input  logic                             out_ready_i,
    output logic                             busy_o,
    output logic                             error_o,
    output logic                             sparse_fsm_error_o
);

    localparam logic [LenW-1:0] MaxLen   = LenW'(MaxOutBytes);
    localparam logic [LenW-1:0] WordLen  = LenW'(8);

    logic [ReaderStateWidth-1:0] state_d, state_q;
    logic [LenW-1:0]             rem_d, rem_q;
    logic [4:0]                  rate_d, rate_q;
    logic [4:0]                  widx_d, widx_q;
    logic                        run_d, run_q;
    logic                        error_d, error_q;

    logic [NumLanes-1:0][63:0]   lanes;
    logic [4:0]                  start_rate;
    logic                        start_legal;
    logic                        is_last;

    // Recombine the shares into the plain state, viewed as 64-bit lanes.
    always_comb begin
        lanes = '0;
        for (int s = 0; s < NumShare; s++) begin
            lanes = lanes ^ state_i[s];
        end
    end

    assign start_rate  = rate_words(keccak_strength_e'(strength_i));
    assign start_legal = (out_len_i != '0) && (out_len_i <= MaxLen) &&
                         (start_rate != 5'd0);
    // A word carrying the final <= 8 bytes ends the digest; rem never reaches 0.
    assign is_last     = (rem_q <= WordLen);

    prim_sparse_fsm_flop #(
        .Width      (ReaderStateWidth),
        .ResetValue (StIdle)
    ) u_state_regs (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .state_i (state_d),
        .state_o (state_q)
    );

    // Next-state and datapath update; invalid codes collapse into StTerminal.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        rate_d  = rate_q;
        widx_d  = widx_q;
        run_d   = 1'b0;
        error_d = 1'b0;

        if (start_i && (state_q != StIdle)) begin
            error_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (start_legal) begin
                        rem_d   = out_len_i;
                        rate_d  = start_rate;
                        widx_d  = 5'd0;
                        state_d = StWaitValid;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            StWaitValid: begin
                if (state_valid_i) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if (!state_valid_i) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else if (out_ready_i) begin
                    if (is_last) begin
                        state_d = StDone;
                    end else if (widx_q == rate_q - 5'd1) begin
                        rem_d   = rem_q - WordLen;
                        widx_d  = 5'd0;
                        run_d   = 1'b1;
                        state_d = StWaitRun;
                    end else begin
                        rem_d   = rem_q - WordLen;
                        widx_d  = widx_q + 5'd1;
                    end
                end
            end
            StWaitRun: begin
                if (block_processed_i) begin
                    state_d = StWaitValid;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StTerminal: begin
                state_d = StTerminal;
            end
            default: begin
                state_d = StTerminal;
            end
        endcase
    end

    // Length, rate and word counters plus the registered pulse outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q   <= '0;
            rate_q  <= 5'd0;
            widx_q  <= 5'd0;
            run_q   <= 1'b0;
            error_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            rate_q  <= rate_d;
            widx_q  <= widx_d;
            run_q   <= run_d;
            error_q <= error_d;
        end
    end

    // Output decode from the current state; stream data is a lane mux on widx.
    always_comb begin
        run_o              = run_q;
        done_o             = 1'b0;
        out_valid_o        = 1'b0;
        out_data_o         = 64'd0;
        out_strb_o         = 8'd0;
        out_last_o         = 1'b0;
        busy_o             = (state_q != StIdle);
        error_o            = error_q;
        sparse_fsm_error_o = 1'b0;

        case (state_q)
            StIdle, StWaitValid, StWaitRun: begin
            end
            StStream: begin
                out_valid_o = state_valid_i;
                out_data_o  = lanes[widx_q];
                out_strb_o  = is_last ? (8'hFF >> (4'd8 - rem_q[3:0])) : 8'hFF;
                out_last_o  = is_last;
            end
            StDone: begin
                done_o = 1'b1;
            end
            StTerminal: begin
                run_o              = 1'b0;
                sparse_fsm_error_o = 1'b1;
            end
            default: begin
                run_o              = 1'b0;
                sparse_fsm_error_o = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sha3_digest_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha3_digest_reader
// Description : Directed self-checking bench for the SHA3 digest reader.
// Revision    : 1.0 - initial version
// ============================================================================
module tb_sha3_digest_reader;

    localparam int LenW = 10;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              start_i = 1'b0;
    logic [LenW-1:0]   out_len_i = '0;
    logic [2:0]        strength_i = 3'd0;
    logic              state_valid_i = 1'b0;
    logic [1:0][1599:0] state_i = '0;
    logic              block_processed_i = 1'b0;
    logic              run_o, done_o, out_valid_o, out_last_o;
    logic [63:0]       out_data_o;
    logic [7:0]        out_strb_o;
    logic              out_ready_i = 1'b0;
    logic              busy_o, error_o, sparse_fsm_error_o;

    int checks = 0;
    int errors = 0;
    int run_cnt = 0;
    int done_cnt = 0;

    logic [63:0] lane0 [25];
    logic [63:0] lane1 [25];
    logic [63:0] cap_data [$];
    logic [7:0]  cap_strb [$];
    logic        cap_last [$];

    sha3_digest_reader #(
        .EnMasking   (1),
        .MaxOutBytes (512)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .start_i            (start_i),
        .out_len_i          (out_len_i),
        .strength_i         (strength_i),
        .state_valid_i      (state_valid_i),
        .state_i            (state_i),
        .block_processed_i  (block_processed_i),
        .run_o              (run_o),
        .done_o             (done_o),
        .out_valid_o        (out_valid_o),
        .out_data_o         (out_data_o),
        .out_strb_o         (out_strb_o),
        .out_last_o         (out_last_o),
        .out_ready_i        (out_ready_i),
        .busy_o             (busy_o),
        .error_o            (error_o),
        .sparse_fsm_error_o (sparse_fsm_error_o)
    );

    always #5 clk_i = ~clk_i;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk_i) begin
        if (run_o === 1'b1) run_cnt = run_cnt + 1;
        if (done_o === 1'b1) done_cnt = done_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Lane i byte b = base + 8*i + b; second share zero.
    task automatic fill_pattern(input int base);
        for (int i = 0; i < 25; i++) begin
            for (int b = 0; b < 8; b++) lane0[i][8*b +: 8] = 8'(base + 8*i + b);
            lane1[i] = 64'd0;
        end
        for (int i = 0; i < 25; i++) begin
            state_i[0][64*i +: 64] = lane0[i];
            state_i[1][64*i +: 64] = lane1[i];
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 25; i++) begin
            lane0[i] = {$urandom(), $urandom()};
            lane1[i] = {$urandom(), $urandom()};
            state_i[0][64*i +: 64] = lane0[i];
            state_i[1][64*i +: 64] = lane1[i];
        end
    endtask

    task automatic do_start(input int len, input logic [2:0] str);
        start_i    = 1'b1;
        out_len_i  = LenW'(len);
        strength_i = str;
        cyc();
        start_i    = 1'b0;
    endtask

    // Consumes n words, recording them; counts data/strobe changes while stalled.
    task automatic collect(input int n, input bit rnd, output int got, output int viol);
        bit          stalled;
        logic [63:0] pd;
        logic [7:0]  ps;
        int          guard;
        cap_data.delete();
        cap_strb.delete();
        cap_last.delete();
        got = 0; viol = 0; stalled = 0; guard = 0; pd = '0; ps = '0;
        while (got < n && guard < 3000) begin
            out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (out_valid_o === 1'b1) begin
                if (stalled && (out_data_o !== pd || out_strb_o !== ps)) viol++;
                if (out_ready_i) begin
                    cap_data.push_back(out_data_o);
                    cap_strb.push_back(out_strb_o);
                    cap_last.push_back(out_last_o);
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    pd = out_data_o;
                    ps = out_strb_o;
                end
            end else begin
                stalled = 0;
            end
            cyc();
            guard++;
        end
        out_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({out_valid_o, out_data_o, out_strb_o, out_last_o} !== 74'd0) begin
            errors++;
            $display("FAIL reset_stream got %h required 0", {out_valid_o, out_data_o, out_strb_o, out_last_o});
        end
        checks++;
        if ({run_o, done_o, error_o, sparse_fsm_error_o} !== 4'd0) begin
            errors++;
            $display("FAIL reset_pulses got %b required 0000", {run_o, done_o, error_o, sparse_fsm_error_o});
        end
        rst_ni = 1'b1;
        cyc();
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy_o); end
    endtask

    task automatic test_short_digest();
        int got, viol, r0;
        r0 = run_cnt;
        fill_pattern(0);
        state_valid_i = 1'b1;
        do_start(32, 3'd2);
        collect(4, 0, got, viol);
        checks++;
        if (got !== 4) begin errors++; $display("FAIL short_count got %0d required 4", got); end
        for (int k = 0; k < got; k++) begin
            checks++;
            if (cap_data[k] !== lane0[k]) begin errors++; $display("FAIL short_data%0d got %h required %h", k, cap_data[k], lane0[k]); end
            checks++;
            if (cap_strb[k] !== 8'hFF) begin errors++; $display("FAIL short_strb%0d got %h required ff", k, cap_strb[k]); end
            checks++;
            if (cap_last[k] !== (k == 3)) begin errors++; $display("FAIL short_last%0d got %b required %b", k, cap_last[k], k == 3); end
        end
        checks++;
        if (done_o !== 1'b1) begin errors++; $display("FAIL short_done got %b required 1", done_o); end
        cyc();
        checks++;
        if ({done_o, busy_o} !== 2'b00) begin errors++; $display("FAIL short_idle got %b required 00", {done_o, busy_o}); end
        checks++;
        if (run_cnt - r0 !== 0) begin errors++; $display("FAIL short_run got %0d required 0", run_cnt - r0); end
    endtask

    task automatic test_partial_last();
        int got, viol;
        logic [7:0] exp_strb [3];
        exp_strb[0] = 8'hFF; exp_strb[1] = 8'hFF; exp_strb[2] = 8'h0F;
        fill_pattern(16);
        do_start(20, 3'd4);
        collect(3, 0, got, viol);
        checks++;
        if (got !== 3) begin errors++; $display("FAIL partial_count got %0d required 3", got); end
        for (int k = 0; k < got; k++) begin
            checks++;
            if (cap_strb[k] !== exp_strb[k]) begin errors++; $display("FAIL partial_strb%0d got %h required %h", k, cap_strb[k], exp_strb[k]); end
            checks++;
            if (cap_last[k] !== (k == 2)) begin errors++; $display("FAIL partial_last%0d got %b required %b", k, cap_last[k], k == 2); end
        end
        if (got == 3) begin
            checks++;
            if (cap_data[2][31:0] !== state_i[0][159:128]) begin
                errors++; $display("FAIL partial_data2 got %h required %h", cap_data[2][31:0], state_i[0][159:128]);
            end
        end
        checks++;
        if (done_o !== 1'b1) begin errors++; $display("FAIL partial_done got %b required 1", done_o); end
        cyc();
    endtask

    task automatic test_xof_blocks();
        int got, viol, r0;
        r0 = run_cnt;
        fill_pattern(0);
        do_start(200, 3'd0);
        collect(21, 0, got, viol);
        checks++;
        if (got !== 21) begin errors++; $display("FAIL xof_count1 got %0d required 21", got); end
        for (int k = 0; k < got; k++) begin
            checks++;
            if ({cap_data[k], cap_strb[k], cap_last[k]} !== {lane0[k], 8'hFF, 1'b0}) begin
                errors++; $display("FAIL xof_word%0d got %h/%h/%b required %h/ff/0", k, cap_data[k], cap_strb[k], cap_last[k], lane0[k]);
            end
        end
        checks++;
        if (run_o !== 1'b1) begin errors++; $display("FAIL xof_run_pulse got %b required 1", run_o); end
        state_valid_i = 1'b0;
        fill_pattern(100);
        cyc();
        checks++;
        if ({run_o, out_valid_o, busy_o} !== 3'b001) begin errors++; $display("FAIL xof_waitrun got %b required 001", {run_o, out_valid_o, busy_o}); end
        block_processed_i = 1'b1;
        cyc();
        block_processed_i = 1'b0;
        cyc();
        checks++;
        if ({out_valid_o, busy_o} !== 2'b01) begin errors++; $display("FAIL xof_waitvalid got %b required 01", {out_valid_o, busy_o}); end
        state_valid_i = 1'b1;
        collect(4, 0, got, viol);
        checks++;
        if (got !== 4) begin errors++; $display("FAIL xof_count2 got %0d required 4", got); end
        for (int k = 0; k < got; k++) begin
            checks++;
            if ({cap_data[k], cap_strb[k], cap_last[k]} !== {lane0[k], 8'hFF, (k == 3)}) begin
                errors++; $display("FAIL xof_tail%0d got %h/%h/%b required %h/ff/%b", k, cap_data[k], cap_strb[k], cap_last[k], lane0[k], k == 3);
            end
        end
        checks++;
        if (done_o !== 1'b1) begin errors++; $display("FAIL xof_done got %b required 1", done_o); end
        cyc();
        checks++;
        if (run_cnt - r0 !== 1) begin errors++; $display("FAIL xof_run_count got %0d required 1", run_cnt - r0); end
    endtask

    task automatic test_backpressure();
        int got, viol, r0;
        r0 = run_cnt;
        fill_random();
        do_start(100, 3'd3);
        collect(13, 1, got, viol);
        checks++;
        if (got !== 13) begin errors++; $display("FAIL bp_count got %0d required 13", got); end
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL bp_stable got %0d changes required 0", viol); end
        for (int k = 0; k < got; k++) begin
            checks++;
            if (cap_data[k] !== (lane0[k] ^ lane1[k])) begin
                errors++; $display("FAIL bp_data%0d got %h required %h", k, cap_data[k], lane0[k] ^ lane1[k]);
            end
            checks++;
            if ({cap_strb[k], cap_last[k]} !== ((k == 12) ? {8'h0F, 1'b1} : {8'hFF, 1'b0})) begin
                errors++; $display("FAIL bp_strb%0d got %h/%b", k, cap_strb[k], cap_last[k]);
            end
        end
        checks++;
        if (done_o !== 1'b1) begin errors++; $display("FAIL bp_done got %b required 1", done_o); end
        cyc();
        checks++;
        if (run_cnt - r0 !== 0) begin errors++; $display("FAIL bp_run got %0d required 0", run_cnt - r0); end
    endtask

    task automatic test_err_start();
        int lens [3];
        logic [2:0] strs [3];
        lens[0] = 0;   strs[0] = 3'd2;
        lens[1] = 513; strs[1] = 3'd2;
        lens[2] = 32;  strs[2] = 3'd5;
        for (int t = 0; t < 3; t++) begin
            do_start(lens[t], strs[t]);
            checks++;
            if ({error_o, busy_o} !== 2'b10) begin errors++; $display("FAIL err_start%0d got %b required 10", t, {error_o, busy_o}); end
            cyc();
            checks++;
            if ({error_o, busy_o} !== 2'b00) begin errors++; $display("FAIL err_clear%0d got %b required 00", t, {error_o, busy_o}); end
        end
    endtask

    task automatic test_start_midstream();
        int got, viol;
        fill_pattern(40);
        do_start(32, 3'd2);
        collect(2, 0, got, viol);
        out_ready_i = 1'b0;
        start_i     = 1'b1;
        out_len_i   = LenW'(8);
        cyc();
        start_i     = 1'b0;
        checks++;
        if ({error_o, busy_o} !== 2'b11) begin errors++; $display("FAIL mid_start_err got %b required 11", {error_o, busy_o}); end
        collect(2, 0, got, viol);
        checks++;
        if (got !== 2) begin errors++; $display("FAIL mid_count got %0d required 2", got); end
        for (int k = 0; k < got; k++) begin
            checks++;
            if ({cap_data[k], cap_last[k]} !== {lane0[k+2], (k == 1)}) begin
                errors++; $display("FAIL mid_word%0d got %h/%b required %h/%b", k, cap_data[k], cap_last[k], lane0[k+2], k == 1);
            end
        end
        checks++;
        if (done_o !== 1'b1) begin errors++; $display("FAIL mid_done got %b required 1", done_o); end
        cyc();
    endtask

    task automatic test_valid_drop();
        int got, viol, d0;
        fill_pattern(0);
        do_start(64, 3'd2);
        collect(3, 0, got, viol);
        d0 = done_cnt;
        state_valid_i = 1'b0;
        #1;
        checks++;
        if (out_valid_o !== 1'b0) begin errors++; $display("FAIL drop_valid got %b required 0", out_valid_o); end
        cyc();
        checks++;
        if ({error_o, busy_o} !== 2'b10) begin errors++; $display("FAIL drop_err got %b required 10", {error_o, busy_o}); end
        repeat (3) cyc();
        checks++;
        if (done_cnt - d0 !== 0) begin errors++; $display("FAIL drop_done got %0d required 0", done_cnt - d0); end
        state_valid_i = 1'b1;
    endtask

    task automatic test_reset_waitrun();
        int got, viol, r0, d0;
        fill_pattern(0);
        do_start(200, 3'd0);
        collect(21, 0, got, viol);
        r0 = run_cnt;
        d0 = done_cnt;
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b required 1", busy_o); end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({run_o, done_o, out_valid_o, busy_o, error_o} !== 5'd0) begin
            errors++; $display("FAIL rst_mid_outputs got %b required 00000", {run_o, done_o, out_valid_o, busy_o, error_o});
        end
        repeat (2) cyc();
        rst_ni = 1'b1;
        repeat (3) cyc();
        checks++;
        if ({run_cnt - r0, done_cnt - d0} !== 64'd0) begin errors++; $display("FAIL rst_mid_pulses got %0d/%0d required 0/0", run_cnt - r0, done_cnt - d0); end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got %b required 0", busy_o); end
    endtask

    task automatic test_fsm_fault();
        force dut.u_state_regs.state_q = 6'b100000;
        #1;
        checks++;
        if (sparse_fsm_error_o !== 1'b1) begin errors++; $display("FAIL fault_flag got %b required 1", sparse_fsm_error_o); end
        repeat (2) cyc();
        release dut.u_state_regs.state_q;
        repeat (2) cyc();
        do_start(32, 3'd2);
        repeat (2) cyc();
        checks++;
        if ({sparse_fsm_error_o, busy_o, out_valid_o, run_o, done_o} !== 5'b11000) begin
            errors++; $display("FAIL fault_hold got %b required 11000", {sparse_fsm_error_o, busy_o, out_valid_o, run_o, done_o});
        end
        checks++;
        if ({out_data_o, out_strb_o, out_last_o} !== 73'd0) begin errors++; $display("FAIL fault_stream got %h required 0", out_data_o); end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({sparse_fsm_error_o, busy_o} !== 2'b00) begin errors++; $display("FAIL fault_reset got %b required 00", {sparse_fsm_error_o, busy_o}); end
        cyc();
        rst_ni = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_short_digest();
        test_partial_last();
        test_xof_blocks();
        test_backpressure();
        test_err_start();
        test_start_midstream();
        test_valid_drop();
        test_reset_waitrun();
        test_fsm_fault();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
